// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter
// Round-robin arbiter for one NoC router output port. It pops flits from
// the winning input FIFO and forwards them to the output link, one flit
// every two cycles. The grant stays locked to one input until that
// packet's tail has passed. Credits track free slots in the neighbour's
// input FIFO, so the downstream buffer is never overrun.
//
// Optional feature:
//   RR_ARB_ERR_CHECK_EN - when defined, a sticky err flag is set if the
//   flit types break packet framing. This is a head/single flit expected
//   after an idle grant, or a body/tail flit expected inside a locked
//   packet. When the macro is undefined, err is tied low.
//
// Flit type lives in the two MSBs of every flit:
//   2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).

module rr_output_arbiter #(
    parameter int NUM_BITS = 8,
    parameter int NUM_IN   = 5,
    parameter int CREDITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*NUM_BITS-1:0]   flit_in,
    input  logic                         credit_in,
    output logic [NUM_IN-1:0]            rd_en,
    output logic [NUM_BITS-1:0]          flit_out,
    output logic                         wr_en_out,
    output logic [NUM_IN-1:0]            grant,
    output logic [$clog2(CREDITS):0]     credit_cnt,
    output logic                         err
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(CREDITS) + 1;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);
    // Input 0 gets first priority after reset because the search starts at rr_ptr+1.
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_IN - 1);

    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [NUM_BITS-1:0] flits [NUM_IN];
    logic [IDX_W-1:0]    winner;
    logic                winner_vld;
    logic [NUM_BITS-1:0] owner_flit;
    logic [1:0]          owner_type;
    logic                has_credit;
    logic                pop;

    // Credit count after one cycle. A pop and a returned credit cancel out.
    // A returned credit is dropped when the count is already full.
    function automatic logic [CNT_W-1:0] credit_next(
        input logic [CNT_W-1:0] cnt,
        input logic             dec,
        input logic             inc
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (dec && !inc) begin
            nxt = cnt - 1'b1;
        end else if (inc && !dec && (cnt != CREDIT_MAX)) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

    // A tail or a single flit closes the packet and releases the grant.
    function automatic logic is_last(input logic [1:0] ftype);
        return (ftype == TYPE_TAIL) || (ftype == TYPE_SINGLE);
    endfunction

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign flits[i] = flit_in[i*NUM_BITS +: NUM_BITS];
    end

    assign owner_flit = flits[owner];
    assign owner_type = owner_flit[NUM_BITS-1 -: 2];
    assign has_credit = (credit_cnt != '0);
    assign pop        = |rd_en;

    // Round-robin search: first requester at or after rr_ptr+1, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        winner     = '0;
        winner_vld = 1'b0;
        for (int off = 1; off <= NUM_IN; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_IN;
            if (!winner_vld && req[IDX_W'(idx)]) begin
                winner     = IDX_W'(idx);
                winner_vld = 1'b1;
            end
        end
    end

    // Pop strobe: a new winner when idle, or only the owner while locked.
    // It is held low in reset so a FIFO is never popped then.
    always_comb begin
        rd_en = '0;
        if (rst_n && has_credit) begin
            case (state)
                IDLE:    if (winner_vld) rd_en[winner] = 1'b1;
                LOCK:    if (req[owner]) rd_en[owner] = 1'b1;
                default: rd_en = '0;
            endcase
        end
    end

    // Downstream credit counter: one slot per pop, one back per credit_in pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_MAX;
        end else begin
            credit_cnt <= credit_next(credit_cnt, pop, credit_in);
        end
    end

    // Arbitration FSM with registered grant and output link.
    // A pop is followed by a capture cycle, where the FIFO data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= PTR_RESET;
            owner     <= '0;
            grant     <= '0;
            flit_out  <= '0;
            wr_en_out <= 1'b0;
        end else begin
            wr_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        owner <= winner;
                        grant <= rd_en;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    flit_out  <= owner_flit;
                    wr_en_out <= 1'b1;
                    if (is_last(owner_type)) begin
                        // The next search begins just past this packet's owner.
                        rr_ptr <= owner;
                        grant  <= '0;
                        state  <= IDLE;
                    end else begin
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (pop) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RR_ARB_ERR_CHECK_EN
    localparam logic [1:0] TYPE_HEAD = 2'b01;

    logic expect_head;

    // A flit that opens a packet is a head or a single flit.
    function automatic logic type_error(input logic want_head, input logic [1:0] ftype);
        logic starts;
        starts = (ftype == TYPE_HEAD) || (ftype == TYPE_SINGLE);
        return want_head ? !starts : starts;
    endfunction

    // Framing checker: note whether the flit in flight opens a packet,
    // then flag a wrong type when it is captured. The flag stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_head <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (pop) begin
                expect_head <= (state == IDLE);
            end
            if ((state == WAIT) && type_error(expect_head, owner_type)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed testbench for rr_output_arbiter.
// The bench models the input FIFOs as queues with registered outputs. Each
// pop is pushed to a scoreboard that holds the expected flit and the cycle
// it should appear on the link. Each test also compares against fixed
// expected orderings and credit values.

module tb_rr_output_arbiter;

    localparam int NB = 8;
    localparam int NI = 5;
    localparam int CR = 8;

`ifdef RR_ARB_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [NI-1:0]          req;
    logic [NI*NB-1:0]       flit_in;
    logic                   credit_in;
    logic [NI-1:0]          rd_en;
    logic [NB-1:0]          flit_out;
    logic                   wr_en_out;
    logic [NI-1:0]          grant;
    logic [$clog2(CR):0]    credit_cnt;
    logic                   err;

    rr_output_arbiter #(.NUM_BITS(NB), .NUM_IN(NI), .CREDITS(CR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .flit_in    (flit_in),
        .credit_in  (credit_in),
        .rd_en      (rd_en),
        .flit_out   (flit_out),
        .wr_en_out  (wr_en_out),
        .grant      (grant),
        .credit_cnt (credit_cnt),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NB-1:0] data;
        int            cyc;
    } exp_t;

    logic [NB-1:0] q [NI][$];
    exp_t          exp_q [$];
    logic [NB-1:0] out_log [$];
    int            out_cyc [$];

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    int npops = 0;
    int cred_m = CR;

    logic [NI-1:0]       s_rd_en;
    logic [NI-1:0]       s_grant;
    logic [$clog2(CR):0] s_cred;
    logic                s_wr;
    logic [NB-1:0]       s_flit;
    logic                s_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic update_req();
        for (int i = 0; i < NI; i++) req[i] = (q[i].size() != 0);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NI; i++) q[i].delete();
        exp_q.delete();
        out_log.delete();
        out_cyc.delete();
        npops  = 0;
        cred_m = CR;
        req    = '0;
        flit_in = '0;
        credit_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        @(negedge clk);
        check("rst_flit_out", flit_out, 0);
        check("rst_wr_en_out", wr_en_out, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_credit_cnt", credit_cnt, CR);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle: sample at the falling edge, then update the FIFO model after the rising edge.
    task automatic step();
        logic [NI-1:0] pops;
        exp_t e;
        @(negedge clk);
        s_rd_en = rd_en;
        s_grant = grant;
        s_cred  = credit_cnt;
        s_wr    = wr_en_out;
        s_flit  = flit_out;
        s_err   = err;
        check("credit_model", s_cred, cred_m);
        if (s_wr) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_wr", s_wr, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", s_flit, e.data);
                check("sb_latency", cyc, e.cyc);
                out_log.push_back(s_flit);
                out_cyc.push_back(cyc);
            end
        end
        if (s_cred == 0) check("no_pop_at_zero", s_rd_en, 0);
        if ($countones(s_rd_en) > 1) check("rd_en_onehot", s_rd_en, 0);
        pops = s_rd_en;
        for (int i = 0; i < NI; i++) begin
            if (pops[i]) begin
                npops++;
                if (q[i].size() == 0) begin
                    check("pop_without_req", req[i], 1);
                end else begin
                    e.data = q[i][0];
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                end
            end
        end
        if ((pops != 0) && !credit_in) cred_m--;
        else if ((pops == 0) && credit_in && (cred_m < CR)) cred_m++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (pops[i] && (q[i].size() != 0)) flit_in[i*NB +: NB] = q[i].pop_front();
        end
        update_req();
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [NB-1:0] exp_cont [6];
        logic [NB-1:0] exp_worm [4];
        logic [NB-1:0] exp_stall [10];
        exp_cont  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hE0};
        exp_worm  = '{8'h41, 8'h07, 8'h89, 8'hC3};
        exp_stall = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h80};

        // ---- single-flit packet on input 2 ----
        do_reset();
        q[2].push_back(8'hC5);
        update_req();
        step();
        check("single_rd_en_c0", s_rd_en, 5'b00100);
        step();
        check("single_rd_en_c1", s_rd_en, 0);
        check("single_grant_c1", s_grant, 5'b00100);
        check("single_credit_c1", s_cred, 7);
        step();
        check("single_wr_c2", s_wr, 1);
        check("single_flit_c2", s_flit, 8'hC5);
        check("single_grant_c2", s_grant, 0);
        step();
        check("single_wr_c3", s_wr, 0);
        check("single_credit_c3", s_cred, 7);
        check("single_err", s_err, 0);
        check("single_drain", exp_q.size(), 0);

        // ---- contention: all inputs, single-flit packets ----
        do_reset();
        q[0].push_back(8'hC0);
        q[0].push_back(8'hE0);
        for (int i = 1; i < NI; i++) q[i].push_back(8'hC0 + 8'(i));
        update_req();
        steps(14);
        check("cont_count", out_log.size(), 6);
        for (int k = 0; k < 6; k++) check("cont_order", out_log[k], exp_cont[k]);
        for (int k = 1; k < 6; k++) check("cont_spacing", out_cyc[k] - out_cyc[k-1], 2);
        check("cont_err", s_err, 0);
        check("cont_drain", exp_q.size(), 0);

        // ---- wormhole lock: input 1 packet, input 3 waiting ----
        do_reset();
        q[1].push_back(8'h41);
        q[1].push_back(8'h07);
        q[1].push_back(8'h89);
        q[3].push_back(8'hC3);
        update_req();
        steps(3);
        check("worm_grant_lock", s_grant, 5'b00010);
        steps(7);
        check("worm_count", out_log.size(), 4);
        for (int k = 0; k < 4; k++) check("worm_order", out_log[k], exp_worm[k]);
        for (int k = 1; k < 4; k++) check("worm_spacing", out_cyc[k] - out_cyc[k-1], 2);
        check("worm_err", s_err, 0);
        check("worm_drain", exp_q.size(), 0);

        // ---- credit stall: 10-flit packet, 8 credits ----
        do_reset();
        for (int k = 0; k < 10; k++) q[0].push_back(exp_stall[k]);
        update_req();
        steps(20);
        check("stall_pops", npops, 8);
        check("stall_credit", s_cred, 0);
        check("stall_rd_en", s_rd_en, 0);
        check("stall_grant", s_grant, 5'b00001);
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        step();
        check("stall_release_rd_en", s_rd_en, 5'b00001);
        steps(3);
        check("stall_one_pop_only", npops, 9);
        check("stall_rd_en_again", s_rd_en, 0);
        credit_in = 1'b1;
        step();
        step();
        check("stall_simul_rd_en", s_rd_en, 5'b00001);
        check("stall_simul_pre", s_cred, 1);
        credit_in = 1'b0;
        step();
        check("stall_simul_post", s_cred, 1);
        steps(2);
        check("stall_grant_released", s_grant, 0);
        check("stall_count", out_log.size(), 10);
        for (int k = 0; k < 10; k++) check("stall_order", out_log[k], exp_stall[k]);
        check("stall_drain", exp_q.size(), 0);

        // ---- reset mid-packet ----
        do_reset();
        q[0].push_back(8'hC0);
        q[2].push_back(8'h42);
        q[2].push_back(8'h02);
        q[2].push_back(8'h03);
        q[2].push_back(8'h82);
        update_req();
        steps(6);
        rst_n = 1'b0;
        #1;
        check("midrst_flit_out", flit_out, 0);
        check("midrst_wr_en_out", wr_en_out, 0);
        check("midrst_grant", grant, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_credit", credit_cnt, CR);
        do_reset();
        q[0].push_back(8'hD0);
        q[1].push_back(8'hD1);
        update_req();
        step();
        check("midrst_first_rd_en", s_rd_en, 5'b00001);
        steps(5);
        check("midrst_count", out_log.size(), 2);
        check("midrst_first_out", out_log[0], 8'hD0);
        check("midrst_second_out", out_log[1], 8'hD1);

        // ---- framing error: body flit from idle ----
        do_reset();
        q[1].push_back(8'h12);
        update_req();
        steps(2);
        check("err_before_capture", s_err, 0);
        step();
        check("err_after_capture", s_err, EXP_ERR);
        check("err_body_forwarded", s_flit, 8'h12);
        steps(3);
        check("err_sticky", s_err, EXP_ERR);
        do_reset();
        step();
        check("err_cleared", s_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

Per-output-port round-robin arbiter with wormhole packet locking and credit-based flow control for the NoC router. It sits directly downstream of the per-input-port flit FIFOs. It pops flits from the winning FIFO and forwards them to the output link, registered, with a write strobe. The output link feeds the neighbour router's input FIFO. It holds the grant until the packet's tail flit passes and never overruns the downstream buffer.

## Interface
- NUM_BITS, 8, flit width; bits [NUM_BITS-1:NUM_BITS-2] are the flit type
- NUM_IN, 5, number of input FIFOs competing for this output
- CREDITS, 8, depth of the downstream FIFO; initial credit count
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_IN  req[i]=1: FIFO i is non-empty and its packet targets this port
- flit_in  in  NUM_IN*NUM_BITS  FIFO outputs; slice i = flit_in[i*NUM_BITS +: NUM_BITS]
- credit_in  in  1  one-cycle pulse per flit popped from the downstream FIFO
- rd_en  out  NUM_IN  one-hot pop strobe to the input FIFOs (combinational)
- flit_out  out  NUM_BITS  registered flit to the output link
- wr_en_out  out  1  registered one-cycle strobe: flit_out is valid
- grant  out  NUM_IN  one-hot current owner, 0 when idle (registered)
- credit_cnt  out  clog2(CREDITS)+1  available downstream slots
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- FSM states:
  - IDLE: if any req and credit_cnt>0, pick a winner g by round-robin starting at rr_ptr+1 (mod NUM_IN). Assert rd_en[g] this cycle, decrement credit, set grant=g, and go to WAIT. Otherwise stay.
  - WAIT: rd_en=0. The FIFO output is now valid. On the edge: flit_out<=flit_in slice g and wr_en_out<=1.
    - If the type is tail or single: rr_ptr<=g, grant<=0, go to IDLE.
    - Otherwise go to LOCK.
  - LOCK: if req[g] and credit_cnt>0, assert rd_en[g], decrement credit, and go to WAIT. Otherwise stay; other inputs are ignored.
- Credits:
  - Decrement on every rd_en issue; increment on credit_in.
  - Both in the same cycle leave the count unchanged.
  - credit_in while credit_cnt==CREDITS is ignored (saturate).
  - No pop is ever issued at credit_cnt==0.
- rr_ptr updates only at packet end, so the next search starts at the input after the last packet's owner.
- Reset values:
  - state=IDLE, rr_ptr=NUM_IN-1 (input 0 is first priority), credit_cnt=CREDITS.
  - flit_out=0, wr_en_out=0, grant=0, err=0, rd_en=0.
- Reset mid-packet aborts the packet. No partial-packet recovery; upstream and downstream are reset together.

## Timing
- Pop to output: rd_en in cycle N gives flit_out/wr_en_out valid in cycle N+2.
- Throughput: at most one flit per 2 cycles per output (pop, capture, alternating).
- Arbitration decision and rd_en are combinational from req, state and credit_cnt in the same cycle.
- Grant-to-release: grant clears on the edge that captures the tail. A new arbitration is possible in the following cycle.
- wr_en_out is high for exactly one cycle per forwarded flit.

## Configuration
- RR_ARB_ERR_CHECK_EN defined: err is set and held until reset when either:
  - WAIT after an IDLE grant captures a body or tail flit (expected head or single), or
  - WAIT in a locked packet captures a head or single flit.
  - Flits are still forwarded unchanged and the FSM transitions as normal.
- Not defined: err is tied to 0 and no type checks are synthesized.

## Test plan
- Single-flit packet, 8'hC5 on input 2, req=5'b00100:
  - rd_en[2] pulses in cycle 0; flit_out=8'hC5 with wr_en_out=1 in cycle 2.
  - grant=0 after; credit_cnt 8->7.
- Contention, req=5'b11111 with single-flit packets, after reset: grants in order 0,1,2,3,4,0, one per 2 cycles.
- Wormhole lock:
  - Input 1 sends head 8'h41, body 8'h07, tail 8'h89 while input 3 is requesting.
  - All three flits exit consecutively on alternate cycles before input 3 is granted.
- Credit stall:
  - CREDITS=8, no credit_in, a 10-flit packet.
  - Exactly 8 pops occur, then LOCK holds with rd_en=0.
  - One credit_in pulse releases exactly one more pop.
  - A simultaneous credit_in and pop keeps credit_cnt unchanged.
- Reset mid-packet:
  - Assert rst_n=0 during LOCK.
  - Outputs immediately read zero, credit_cnt=8, and the next arbitration starts at input 0.
- With RR_ARB_ERR_CHECK_EN, a body flit 8'h12 popped from IDLE sets err=1, which remains set until reset. Without the macro, err stays 0.
